// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register writeback queue
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-match lookup of one read index across pending writebacks
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]         entries_i,
    input  logic [$clog2(DEPTH)-1:0]      head_i,
    input  logic [$clog2(DEPTH):0]        count_i,
    input  logic [AW-1:0]                 rs_i,
    output logic                          hit_o,
    output logic [XLEN-1:0]               data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overwrites an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if ((CW'(k) < count_i) && entries_i[idx].valid &&
                (entries_i[idx].rd == rs_i) && (rs_i != REG_ZERO)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order register writeback buffer with read-port forwarding
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_rd,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       wb_enable,
    output logic                       wb_write,
    output logic [AW-1:0]              wb_rd,
    output logic [XLEN-1:0]            wb_data,
    input  logic [AW-1:0]              rs1,
    input  logic [AW-1:0]              rs2,
    output logic                       fwd1_hit,
    output logic [XLEN-1:0]            fwd1_data,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_pkg::wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push_fire;
    logic enq;
    logic pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

    // x0 requests complete the handshake but never occupy a slot.
    assign push_fire = in_valid && in_ready;
    assign enq       = push_fire && (in_rd != wb_pkg::REG_ZERO);

    assign wb_write = !reset && !empty && wb_enable;
    assign pop      = wb_write;
    assign wb_rd    = empty ? '0 : entries_q[head_q].rd;
    assign wb_data  = empty ? '0 : entries_q[head_q].data;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        if (enq) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].rd    = in_rd;
            entries_d[tail_q].data  = in_data;
            tail_d                  = tail_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .rs_i      (rs1),
        .hit_o     (fwd1_hit),
        .data_o    (fwd1_data)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .rs_i      (rs2),
        .hit_o     (fwd2_hit),
        .data_o    (fwd2_data)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - self-checking bench for writeback_queue against a queue model
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, wb_enable, wb_write;
    logic            fwd1_hit, fwd2_hit, empty, full;
    logic [AW-1:0]   in_rd, wb_rd, rs1, rs2;
    logic [XLEN-1:0] in_data, wb_data, fwd1_data, fwd2_data;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t mq[$];

    writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .wb_enable (wb_enable),
        .wb_write  (wb_write),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_fwd(input logic [AW-1:0] rs, output logic hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == rs) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_model();
        logic            h1, h2;
        logic [XLEN-1:0] d1, d2;
        int              n;
        n = mq.size();
        model_fwd(rs1, h1, d1);
        model_fwd(rs2, h2, d2);
        chk("count",     count,     64'(n));
        chk("empty",     empty,     64'(n == 0));
        chk("full",      full,      64'(n == DEPTH));
        chk("in_ready",  in_ready,  64'(n != DEPTH));
        chk("wb_write",  wb_write,  64'(!reset && n > 0 && wb_enable));
        chk("wb_rd",     wb_rd,     n > 0 ? 64'(mq[0].rd) : 64'd0);
        chk("wb_data",   wb_data,   n > 0 ? 64'(mq[0].data) : 64'd0);
        chk("fwd1_hit",  fwd1_hit,  64'(h1));
        chk("fwd1_data", fwd1_data, 64'(d1));
        chk("fwd2_hit",  fwd2_hit,  64'(h2));
        chk("fwd2_data", fwd2_data, 64'(d2));
    endtask

    task automatic model_edge();
        logic do_pop, do_push;
        if (reset) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && wb_enable;
            do_push = in_valid && (mq.size() < DEPTH) && (in_rd != 0);
            if (do_pop)
                void'(mq.pop_front());
            if (do_push)
                mq.push_back('{rd: in_rd, data: in_data});
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] d, input logic en,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        reset     = r;
        in_valid  = v;
        in_rd     = rd;
        in_data   = d;
        wb_enable = en;
        rs1       = a;
        rs2       = b;
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc(input logic r, input logic v, input logic [AW-1:0] rd,
                       input logic [XLEN-1:0] d, input logic en,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
        drive(r, v, rd, d, en, a, b);
        adv();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        wb_enable = 1'b0; rs1 = '0; rs2 = '0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 1, 0, 0);

        // reset state
        drive(0, 0, 0, 0, 1, 1, 2);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_write", wb_write, 0);
        chk("rst_fwd1_hit", fwd1_hit, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        adv();

        // reset mid-operation
        for (int i = 0; i < 3; i++) cyc(0, 1, AW'(1 + i), XLEN'(32'h50 + i), 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 0);
        chk("midrst_no_write", wb_write, 0);
        adv();
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_wb_write", wb_write, 0);
        chk("midrst_fwd1_hit", fwd1_hit, 0);
        adv();

        // fill and stall
        for (int i = 0; i < 4; i++) cyc(0, 1, AW'(5 + i), XLEN'(32'hA + i), 0, 0, 0);
        drive(0, 1, 9, 32'h99, 0, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_count", count, 4);
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("drain_wb_write", wb_write, 1);
            chk("drain_wb_rd", wb_rd, 64'(5 + i));
            chk("drain_wb_data", wb_data, 64'(32'hA + i));
            adv();
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("drain_empty", empty, 1);
        chk("drain_wb_write", wb_write, 0);
        adv();

        // x0 drop
        drive(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0);
        chk("x0_in_ready", in_ready, 1);
        adv();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("x0_count", count, 0);
        chk("x0_wb_write", wb_write, 0);
        chk("x0_fwd1_hit", fwd1_hit, 0);
        adv();

        // youngest-wins forwarding
        cyc(0, 1, 29, 32'hFC, 0, 0, 0);
        cyc(0, 1, 29, 32'h100, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 29, 3);
        chk("young_fwd1_hit", fwd1_hit, 1);
        chk("young_fwd1_data", fwd1_data, 32'h100);
        chk("young_fwd2_hit", fwd2_hit, 0);
        chk("young_fwd2_data", fwd2_data, 0);
        adv();
        cyc(0, 0, 0, 0, 1, 29, 0);
        cyc(0, 0, 0, 0, 1, 29, 0);

        // simultaneous push and pop at count=2, crossing the pointer wrap
        cyc(0, 1, 10, 32'h10, 0, 0, 0);
        cyc(0, 1, 11, 32'h11, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, AW'(12 + i), XLEN'(32'h12 + i), 1, 0, 0);
            chk("pp_count", count, 2);
            chk("pp_wb_rd", wb_rd, 64'(10 + i));
            adv();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("pp_tail_rd", wb_rd, 64'(14 + i));
            chk("pp_tail_data", wb_data, 64'(32'h14 + i));
            adv();
        end

        // forward from the head being popped
        cyc(0, 1, 1, 32'h1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("headfwd_write", wb_write, 1);
        chk("headfwd_hit", fwd1_hit, 1);
        chk("headfwd_data", fwd1_data, 1);
        adv();
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("headfwd_after_hit", fwd1_hit, 0);
        chk("headfwd_after_write", wb_write, 0);
        adv();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                $urandom_range(0, 1),
                AW'($urandom_range(0, 7)),
                XLEN'($urandom),
                ($urandom_range(0, 3) != 0) && (($urandom_range(0, 511) > 40) || n[6]),
                AW'($urandom_range(0, 7)),
                AW'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
